// File: rtl/dmem_lsu_ctrl.sv
// rtl/dmem_lsu_ctrl.sv - load/store sequencer between the memory stage and word-organised data memory
// Define DMEM_MISALIGN_SPLIT_EN to split word-crossing accesses; otherwise misaligned accesses are errors.
module dmem_lsu_ctrl #(
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic [3:0]  mem_we,
  input  logic [31:0] mem_dout
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_e;

  localparam logic [32:0] LIMIT = 33'(MEM_BYTES);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] hi_q, hi_d;

  logic [1:0]  last_ofs;
  logic [32:0] end_addr;
  logic        req_err;
  logic [3:0]  size_mask;
  logic [7:0]  lanes;
  logic [63:0] din_wide;
  logic [31:0] rd_word;
  logic [31:0] rd_ext;

  // End address is computed in 33 bits so requests near 0xFFFFFFFF cannot wrap into range.
  always_comb begin
    case (req_size)
      2'b00:   last_ofs = 2'd0;
      2'b01:   last_ofs = 2'd1;
      default: last_ofs = 2'd3;
    endcase
    end_addr = {1'b0, req_addr} + {31'b0, last_ofs};
    req_err  = (req_size == 2'b11) || (end_addr >= LIMIT);
`ifndef DMEM_MISALIGN_SPLIT_EN
    req_err  = req_err || (req_size == 2'b01 && req_addr[0])
                       || (req_size == 2'b10 && req_addr[1:0] != 2'b00);
`endif
  end

  // Lanes beyond bit 3 spill into the second word of a split access.
  always_comb begin
    case (size_q)
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
    lanes    = {4'b0000, size_mask} << addr_q[1:0];
    din_wide = {32'b0, wdata_q} << {addr_q[1:0], 3'b000};
    rd_word  = 32'({hi_q, lo_q} >> {addr_q[1:0], 3'b000});
    case (size_q)
      2'b00:   rd_ext = uns_q ? {24'b0, rd_word[7:0]}  : {{24{rd_word[7]}}, rd_word[7:0]};
      2'b01:   rd_ext = uns_q ? {16'b0, rd_word[15:0]} : {{16{rd_word[15]}}, rd_word[15:0]};
      default: rd_ext = rd_word;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    size_d    = size_q;
    uns_d     = uns_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_addr  = 32'b0;
    mem_din   = 32'b0;
    mem_we    = 4'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          err_d   = req_err;
          lo_d    = 32'b0;
          hi_d    = 32'b0;
          state_d = req_err ? RESP : ACC0;
        end
      end
      ACC0: begin
        mem_addr = {addr_q[31:2], 2'b00};
        mem_din  = din_wide[31:0];
        mem_we   = we_q ? lanes[3:0] : 4'b0;
        lo_d     = mem_dout;
`ifdef DMEM_MISALIGN_SPLIT_EN
        state_d  = (|lanes[7:4]) ? ACC1 : RESP;
`else
        state_d  = RESP;
`endif
      end
      ACC1: begin
        mem_addr = {addr_q[31:2], 2'b00} + 32'd4;
        mem_din  = din_wide[63:32];
        mem_we   = we_q ? lanes[7:4] : 4'b0;
        hi_d     = mem_dout;
        state_d  = RESP;
      end
      default: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
    endcase
  end

  assign rsp_rdata = (state_q == RESP && !we_q && !err_q) ? rd_ext : 32'b0;
  assign rsp_err   = (state_q == RESP) && err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b0;
      uns_q   <= 1'b0;
      addr_q  <= 32'b0;
      wdata_q <= 32'b0;
      err_q   <= 1'b0;
      lo_q    <= 32'b0;
      hi_q    <= 32'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
    end
  end

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// tb/tb_dmem_lsu_ctrl.sv - directed self-checking bench for dmem_lsu_ctrl with a negedge-write memory model
module tb_dmem_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata, mem_addr, mem_din, mem_dout;
  logic [3:0]  mem_we;

  logic [31:0] mem [0:1023];

  int checks = 0;
  int errors = 0;

  logic [31:0] o_addr [0:1];
  logic [31:0] o_din  [0:1];
  logic [3:0]  o_we   [0:1];
  logic        we_seen;
  int          lat;
  logic [31:0] r_rdata;
  logic        r_err;

  always #5 clk = ~clk;

  dmem_lsu_ctrl #(.MEM_BYTES(4096)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout)
  );

  assign mem_dout = mem[mem_addr[11:2]];

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++)
      if (mem_we[i]) mem[mem_addr[11:2]][8*i +: 8] <= mem_din[8*i +: 8];
  end

  task automatic issue_req(input logic we, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] wd);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    we_seen = |mem_we;
    o_addr[0] = mem_addr; o_we[0] = mem_we; o_din[0] = mem_din;
    o_addr[1] = 32'b0;    o_we[1] = 4'b0;   o_din[1] = 32'b0;
    while (!rsp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
      we_seen = we_seen | (|mem_we);
      if (lat == 2) begin o_addr[1] = mem_addr; o_we[1] = mem_we; o_din[1] = mem_din; end
    end
    if (!rsp_valid) begin
      lat = 99; r_rdata = 'x; r_err = 1'bx;
    end else begin
      r_rdata = rsp_rdata; r_err = rsp_err;
    end
  endtask

  task automatic consume_rsp;
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic xfer(input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd);
    issue_req(we, sz, uns, a, wd);
    consume_rsp();
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b0; req_unsigned = 1'b0;
    req_addr = 32'b0; req_wdata = 32'b0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if ({rsp_rdata, rsp_err, mem_we, mem_addr, mem_din} !== 101'b0) begin
      errors++; $display("FAIL reset_outputs: got rdata=%h err=%b we=%b addr=%h din=%h expected all 0",
                         rsp_rdata, rsp_err, mem_we, mem_addr, mem_din);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_word_store_load;
    issue_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    checks++; if (o_addr[0] !== 32'h10) begin errors++; $display("FAIL sw_addr: got %h expected 00000010", o_addr[0]); end
    checks++; if (o_we[0] !== 4'b1111) begin errors++; $display("FAIL sw_we: got %b expected 1111", o_we[0]); end
    checks++; if (o_din[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_din: got %h expected deadbeef", o_din[0]); end
    checks++; if ({r_rdata, r_err} !== 33'b0) begin errors++; $display("FAIL sw_rsp: got rdata=%h err=%b expected 0/0", r_rdata, r_err); end
    consume_rsp();
    checks++; if (mem[4] !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_mem: got %h expected deadbeef", mem[4]); end
    xfer(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    checks++; if (r_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rdata: got %h expected deadbeef", r_rdata); end
    checks++; if (r_err !== 1'b0) begin errors++; $display("FAIL lw_err: got %b expected 0", r_err); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL lw_latency: got %0d expected 2", lat); end
  endtask

  task automatic test_subword_loads;
    logic [1:0]  t_sz  [0:6] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0, 2'd1};
    logic        t_uns [0:6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] t_a   [0:6] = '{32'h13, 32'h13, 32'h12, 32'h11, 32'h10, 32'h11, 32'h10};
`ifdef DMEM_MISALIGN_SPLIT_EN
    logic [31:0] t_exp [0:6] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000ADBE,
                                 32'hFFFFFFEF, 32'h000000BE, 32'hFFFFBEEF};
    logic        t_err [0:6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`else
    logic [31:0] t_exp [0:6] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h00000000,
                                 32'hFFFFFFEF, 32'h000000BE, 32'hFFFFBEEF};
    logic        t_err [0:6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
`endif
    for (int i = 0; i < 7; i++) begin
      xfer(1'b0, t_sz[i], t_uns[i], t_a[i], 32'h0);
      checks++; if (r_rdata !== t_exp[i]) begin errors++; $display("FAIL sub_rdata[%0d]: got %h expected %h", i, r_rdata, t_exp[i]); end
      checks++; if (r_err !== t_err[i]) begin errors++; $display("FAIL sub_err[%0d]: got %b expected %b", i, r_err, t_err[i]); end
      checks++; if (lat !== (t_err[i] ? 1 : 2)) begin errors++; $display("FAIL sub_latency[%0d]: got %0d expected %0d", i, lat, t_err[i] ? 1 : 2); end
    end
  endtask

  task automatic test_byte_stores;
    xfer(1'b1, 2'b10, 1'b0, 32'h20, 32'hAAAAAAAA);
    issue_req(1'b1, 2'b00, 1'b0, 32'h20, 32'h11);
    checks++; if (o_we[0] !== 4'b0001) begin errors++; $display("FAIL sb0_we: got %b expected 0001", o_we[0]); end
    consume_rsp();
    issue_req(1'b1, 2'b00, 1'b0, 32'h21, 32'h22);
    checks++; if (o_we[0] !== 4'b0010) begin errors++; $display("FAIL sb1_we: got %b expected 0010", o_we[0]); end
    checks++; if (o_din[0][15:8] !== 8'h22) begin errors++; $display("FAIL sb1_din: got %h expected 22 in lane 1", o_din[0]); end
    consume_rsp();
    xfer(1'b0, 2'b01, 1'b1, 32'h20, 32'h0);
    checks++; if (r_rdata !== 32'h00002211) begin errors++; $display("FAIL sb_lhu: got %h expected 00002211", r_rdata); end
    checks++; if (mem[8] !== 32'hAAAA2211) begin errors++; $display("FAIL sb_mem: got %h expected aaaa2211", mem[8]); end
  endtask

  task automatic test_reset_mid_store;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h20; req_wdata = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++; if (mem_we !== 4'b1111) begin errors++; $display("FAIL rst_acc0_we: got %b expected 1111", mem_we); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (mem_we !== 4'b0000) begin errors++; $display("FAIL rst_async_we: got %b expected 0000", mem_we); end
    @(negedge clk); #1;
    checks++; if (mem[8] !== 32'hAAAA2211) begin errors++; $display("FAIL rst_mem: got %h expected aaaa2211", mem[8]); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready: got %b expected 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b expected 0", rsp_valid); end
  endtask

  task automatic test_misaligned;
    xfer(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344);
    xfer(1'b1, 2'b10, 1'b0, 32'h14, 32'h55667788);
`ifdef DMEM_MISALIGN_SPLIT_EN
    xfer(1'b0, 2'b10, 1'b0, 32'h12, 32'h0);
    checks++; if (r_rdata !== 32'h77881122) begin errors++; $display("FAIL split_lw_rdata: got %h expected 77881122", r_rdata); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL split_lw_latency: got %0d expected 3", lat); end
    xfer(1'b0, 2'b01, 1'b0, 32'h11, 32'h0);
    checks++; if (r_rdata !== 32'h00002233 || lat !== 2) begin errors++; $display("FAIL lh_ofs1: got %h lat %0d expected 00002233 lat 2", r_rdata, lat); end
    issue_req(1'b1, 2'b01, 1'b0, 32'h13, 32'h0000ABCD);
    checks++; if (o_we[0] !== 4'b1000 || o_din[0][31:24] !== 8'hCD) begin
      errors++; $display("FAIL split_sh_acc0: got we=%b din=%h expected 1000 / CD in lane 3", o_we[0], o_din[0]);
    end
    checks++; if (o_addr[1] !== 32'h14 || o_we[1] !== 4'b0001 || o_din[1][7:0] !== 8'hAB) begin
      errors++; $display("FAIL split_sh_acc1: got addr=%h we=%b din=%h expected 00000014 / 0001 / AB in lane 0", o_addr[1], o_we[1], o_din[1]);
    end
    consume_rsp();
    checks++; if (mem[4] !== 32'hCD223344 || mem[5] !== 32'h556677AB) begin
      errors++; $display("FAIL split_sh_mem: got %h %h expected cd223344 556677ab", mem[4], mem[5]);
    end
`else
    xfer(1'b0, 2'b10, 1'b0, 32'h12, 32'h0);
    checks++; if (r_err !== 1'b1 || r_rdata !== 32'h0) begin errors++; $display("FAIL mis_lw: got err=%b rdata=%h expected 1 / 0", r_err, r_rdata); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL mis_lw_latency: got %0d expected 1", lat); end
    xfer(1'b1, 2'b01, 1'b0, 32'h13, 32'h0000ABCD);
    checks++; if (r_err !== 1'b1 || we_seen !== 1'b0) begin errors++; $display("FAIL mis_sh: got err=%b we_seen=%b expected 1 / 0", r_err, we_seen); end
    checks++; if (mem[4] !== 32'h11223344 || mem[5] !== 32'h55667788) begin
      errors++; $display("FAIL mis_sh_mem: got %h %h expected 11223344 55667788", mem[4], mem[5]);
    end
`endif
    xfer(1'b1, 2'b11, 1'b0, 32'h18, 32'hFFFFFFFF);
    checks++; if (r_err !== 1'b1 || lat !== 1 || we_seen !== 1'b0) begin
      errors++; $display("FAIL illegal_size: got err=%b lat=%0d we_seen=%b expected 1 / 1 / 0", r_err, lat, we_seen);
    end
  endtask

  task automatic test_range;
    xfer(1'b1, 2'b10, 1'b0, 32'hFFC, 32'hCAFEF00D);
    xfer(1'b0, 2'b10, 1'b0, 32'hFFC, 32'h0);
    checks++; if (r_rdata !== 32'hCAFEF00D || r_err !== 1'b0) begin errors++; $display("FAIL lw_ffc: got %h err=%b expected cafef00d / 0", r_rdata, r_err); end
    xfer(1'b0, 2'b00, 1'b0, 32'hFFF, 32'h0);
    checks++; if (r_rdata !== 32'hFFFFFFCA || r_err !== 1'b0) begin errors++; $display("FAIL lb_fff: got %h err=%b expected ffffffca / 0", r_rdata, r_err); end
    xfer(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0);
    checks++; if (r_err !== 1'b1 || lat !== 1 || r_rdata !== 32'h0) begin errors++; $display("FAIL lw_1000: got err=%b lat=%0d rdata=%h expected 1 / 1 / 0", r_err, lat, r_rdata); end
    xfer(1'b0, 2'b10, 1'b0, 32'hFFFFFFFC, 32'h0);
    checks++; if (r_err !== 1'b1) begin errors++; $display("FAIL lw_wrap: got err=%b expected 1", r_err); end
    xfer(1'b0, 2'b10, 1'b0, 32'hFFE, 32'h0);
    checks++; if (r_err !== 1'b1 || we_seen !== 1'b0 || lat !== 1) begin errors++; $display("FAIL lw_ffe: got err=%b lat=%0d expected 1 / 1", r_err, lat); end
    xfer(1'b1, 2'b10, 1'b0, 32'hFFE, 32'h01020304);
    checks++; if (r_err !== 1'b1 || we_seen !== 1'b0 || mem[1023] !== 32'hCAFEF00D) begin
      errors++; $display("FAIL sw_ffe: got err=%b we_seen=%b mem=%h expected 1 / 0 / cafef00d", r_err, we_seen, mem[1023]);
    end
    xfer(1'b1, 2'b01, 1'b0, 32'hFFF, 32'h0000BEEF);
    checks++; if (r_err !== 1'b1 || mem[1023] !== 32'hCAFEF00D) begin errors++; $display("FAIL sh_fff: got err=%b mem=%h expected 1 / cafef00d", r_err, mem[1023]); end
  endtask

  task automatic test_backpressure;
    issue_req(1'b0, 2'b10, 1'b0, 32'hFFC, 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFEF00D || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
        errors++; $display("FAIL hold[%0d]: got valid=%b rdata=%h err=%b ready=%b expected 1 / cafef00d / 0 / 0",
                           i, rsp_valid, rsp_rdata, rsp_err, req_ready);
      end
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL hold_release_ready: got %b expected 0", req_ready); end
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL hold_idle: got ready=%b valid=%b expected 1 / 0", req_ready, rsp_valid); end
  endtask

  initial begin
    test_reset();
    test_word_store_load();
    test_subword_loads();
    test_byte_stores();
    test_reset_mid_store();
    test_misaligned();
    test_range();
    test_backpressure();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
